// File: rtl/led_rr_sequencer.sv
// rtl/led_rr_sequencer.sv - round-robin sharing of the 6-LED bank between NREQ requesters
// Optional feature macro: LED_RR_PWM_EN (adds 4-bit bright input and PWM dimming of lit bits)
module led_rr_sequencer #(
  parameter int          NREQ     = 4,
  parameter int          TICK_DIV = 27000000,
  parameter int          DWELL    = 2,
  parameter logic [5:0]  IDLE_PAT = 6'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [6*NREQ-1:0] pat,
`ifdef LED_RR_PWM_EN
  input  logic [3:0]        bright,
`endif
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic              busy,
  output logic [5:0]        led
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DWELL + 1);

  typedef enum logic {ST_IDLE, ST_SHOW} state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     last_q, last_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [DW-1:0]     dwell_q, dwell_d;
  logic [5:0]        show_q, show_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              busy_q, busy_d;
  logic [5:0]        led_q, led_d;

  logic              win_found;
  logic [LW-1:0]     win_idx;
  logic [NREQ-1:0]   win_oh;
  logic [5:0]        win_pat;
  logic              window_end;
  logic              owner_req;

`ifdef LED_RR_PWM_EN
  logic [3:0]        pwm_q, pwm_d;
  logic [3:0]        bright_q, bright_d;
`endif

  // Round-robin pick: first requester after the last winner, wrapping modulo NREQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_oh    = '0;
    win_pat   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && req[j] && (j == (int'(last_q) + k) % NREQ)) begin
          win_found  = 1'b1;
          win_idx    = LW'(j);
          win_oh[j]  = 1'b1;
          win_pat    = pat[6*j +: 6];
        end
      end
    end
  end

  // FSM next state, dwell counting and registered-output next values
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    tick_d     = tick_q;
    dwell_d    = dwell_q;
    show_d     = show_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    busy_d     = busy_q;
`ifdef LED_RR_PWM_EN
    bright_d   = bright_q;
`endif
    window_end = (dwell_q == DW'(DWELL - 1)) && (tick_q == TW'(TICK_DIV - 1));
    owner_req  = |(req & gnt_q);
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_SHOW;
          gnt_d    = win_oh;
          busy_d   = 1'b1;
          show_d   = win_pat;
          last_d   = win_idx;
          tick_d   = '0;
          dwell_d  = '0;
`ifdef LED_RR_PWM_EN
          bright_d = bright;
`endif
        end
      end
      ST_SHOW: begin
        // a normal window end takes priority over a simultaneous request drop
        if (window_end || !owner_req) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
          done_d  = window_end ? gnt_q : '0;
          show_d  = IDLE_PAT;
          tick_d  = '0;
          dwell_d = '0;
        end else if (tick_q == TW'(TICK_DIV - 1)) begin
          tick_d  = '0;
          dwell_d = dwell_q + 1'b1;
        end else begin
          tick_d  = tick_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Active-low pin drive; with PWM, a granted pattern is gated by the duty compare
  always_comb begin
`ifdef LED_RR_PWM_EN
    pwm_d = pwm_q + 4'd1;
    if (state_d == ST_SHOW) begin
      led_d = ~(show_d & {6{pwm_d < bright_d}});
    end else begin
      led_d = ~show_d;
    end
`else
    led_d = ~show_d;
`endif
  end

  // State and output registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= LW'(NREQ - 1);
      tick_q   <= '0;
      dwell_q  <= '0;
      show_q   <= IDLE_PAT;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      led_q    <= ~IDLE_PAT;
`ifdef LED_RR_PWM_EN
      pwm_q    <= '0;
      bright_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      tick_q   <= tick_d;
      dwell_q  <= dwell_d;
      show_q   <= show_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
`ifdef LED_RR_PWM_EN
      pwm_q    <= pwm_d;
      bright_q <= bright_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign led  = led_q;

endmodule

// File: tb/tb_led_rr_sequencer.sv
// tb/tb_led_rr_sequencer.sv - scoreboard bench for led_rr_sequencer with a window-level reference model
module tb_led_rr_sequencer;

  localparam int         NREQ     = 4;
  localparam int         TICK_DIV = 4;
  localparam int         DWELL    = 2;
  localparam int         WIN      = TICK_DIV * DWELL;
  localparam logic [5:0] IDLE_PAT = 6'h00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [23:0] pat = '0;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [5:0]  led;
`ifdef LED_RR_PWM_EN
  logic [3:0]  bright = 4'hF;
`endif

  led_rr_sequencer #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .DWELL(DWELL), .IDLE_PAT(IDLE_PAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .pat(pat),
`ifdef LED_RR_PWM_EN
    .bright(bright),
`endif
    .gnt(gnt),
    .done(done),
    .busy(busy),
    .led(led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       busy;
    logic [5:0] led;
  } obs_t;

  int   errors = 0;
  int   checks = 0;
  obs_t exp_q[$];

  // reference model: who owns the bank and how many cycles of its window remain
  int         m_owner = -1;
  int         m_left  = 0;
  int         m_last  = NREQ - 1;
  logic [5:0] m_shown = IDLE_PAT;

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_last  = NREQ - 1;
    m_shown = IDLE_PAT;
  endtask

  task automatic model_step(output obs_t e);
    logic [3:0] d;
    d = '0;
    if (m_owner < 0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (((req >> c) & 4'd1) != 4'd0) begin
          m_owner = c;
          m_last  = c;
          m_left  = WIN;
          m_shown = 6'(pat >> (6 * c));
          break;
        end
      end
    end else if (m_left == 1) begin
      d       = 4'(1 << m_owner);
      m_owner = -1;
      m_shown = IDLE_PAT;
    end else if (((req >> m_owner) & 4'd1) == 4'd0) begin
      m_owner = -1;
      m_shown = IDLE_PAT;
    end else begin
      m_left = m_left - 1;
    end
    e.gnt  = (m_owner < 0) ? 4'd0 : 4'(1 << m_owner);
    e.done = d;
    e.busy = (m_owner >= 0);
    e.led  = ~m_shown;
  endtask

  task automatic compare(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b done=%b busy=%b led=%h want gnt=%b done=%b busy=%b led=%h",
               name, $time, got.gnt, got.done, got.busy, got.led,
               want.gnt, want.done, want.busy, want.led);
    end
  endtask

  // drive one cycle of inputs and queue the response expected after the next edge
  task automatic cycle(input logic [3:0] r, input logic [23:0] p);
    obs_t e;
    @(negedge clk);
    req = r;
    pat = p;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_values(input string name);
    obs_t got;
    obs_t want;
    got  = {gnt, done, busy, led};
    want = {4'd0, 4'd0, 1'b0, ~IDLE_PAT};
    compare(name, got, want);
  endtask

  // asynchronous reset in the middle of whatever is running
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    req = '0;
    repeat (hold) @(negedge clk);
    check_reset_values("reset_hold");
    rst = 1'b1;
  endtask

  // monitor: compare every registered output update against the scoreboard
  always begin
    obs_t got;
    obs_t want;
    @(posedge clk);
    #1;
    if (rst && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got  = {gnt, done, busy, led};
      compare("cycle", got, want);
    end
  end

  initial begin
    obs_t got;
    obs_t want;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    rst = 1'b1;

    // idle with no requests
    repeat (20) cycle(4'b0000, 24'($urandom));

    // single requester, pattern 2A, repeated windows with 1-cycle gaps
    repeat (20) cycle(4'b0001, {18'($urandom), 6'h2A});

    // all requesting: rotation 0,1,2,3,0 with pattern churn every cycle
    repeat (40) cycle(4'b1111, 24'($urandom));

    // requester 2 aborts after 3 cycles of show, then 3 beats 2 on fairness
    repeat (4) cycle(4'b0100, 24'($urandom));
    repeat (3) cycle(4'b0000, 24'($urandom));
    repeat (20) cycle(4'b1100, 24'($urandom));
    repeat (2) cycle(4'b0000, 24'($urandom));

    // mid-window reset, then requester 0 must win first
    repeat (5) cycle(4'b0001, 24'h00002A);
    do_reset(3);
    repeat (12) cycle(4'b1111, 24'($urandom));

    // randomized request levels held for random lengths
    for (int n = 0; n < 40; n++) begin
      logic [3:0] r;
      int         len;
      r   = 4'($urandom);
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < len; i++) cycle(r, 24'($urandom));
      if (n == 20) do_reset(2);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    req = '0;
    repeat (2) @(negedge clk);
    got  = {gnt, done, busy, led};
    want = {4'd0, 4'd0, 1'b0, ~IDLE_PAT};
    compare("final_idle", got, want);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
